// File: rtl/dtree_pkg.sv
// Shared types for the decision-tree sequencer: FSM states, node-word layout and decode.
package dtree_pkg;

    localparam int NODE_W    = 28;
    localparam int LEAF_BIT  = 27;
    localparam int FIDX_LSB  = 24;
    localparam int FIDX_W    = 3;
    localparam int SHIFT_LSB = 21;
    localparam int SHIFT_W   = 3;
    localparam int THR_LSB   = 13;
    localparam int THR_W     = 8;
    localparam int RIGHT_LSB = 5;
    localparam int RIGHT_W   = 8;
    localparam int RSVD_LSB  = 2;
    localparam int RSVD_W    = 3;
    localparam int CLS_LSB   = 0;
    localparam int CLS_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EVAL,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic               leaf;
        logic [FIDX_W-1:0]  fidx;
        logic [SHIFT_W-1:0] shift;
        logic [THR_W-1:0]   thr;
        logic [RIGHT_W-1:0] right;
        logic [RSVD_W-1:0]  rsvd;
        logic [CLS_W-1:0]   cls;
    } node_t;

    function automatic node_t decode_node(input logic [NODE_W-1:0] w);
        node_t n;
        n.leaf  = w[LEAF_BIT];
        n.fidx  = w[FIDX_LSB +: FIDX_W];
        n.shift = w[SHIFT_LSB +: SHIFT_W];
        n.thr   = w[THR_LSB +: THR_W];
        n.right = w[RIGHT_LSB +: RIGHT_W];
        n.rsvd  = w[RSVD_LSB +: RSVD_W];
        n.cls   = w[CLS_LSB +: CLS_W];
        return n;
    endfunction

endpackage

// File: rtl/dtree_node_cmp.sv
// Combinational node test: pick feature X[fidx], shift it right (zero-fill) and
// compare unsigned against the node threshold; flags feature indices out of range.
module dtree_node_cmp
    import dtree_pkg::*;
#(
    parameter int N_FEAT = 6
) (
    input  logic [N_FEAT*8-1:0]  feats,
    input  logic [FIDX_W-1:0]    fidx,
    input  logic [SHIFT_W-1:0]   shift,
    input  logic [THR_W-1:0]     thr,
    output logic                 le,
    output logic                 bad_idx
);

    logic [7:0] sel;

    always_comb begin
        sel = '0;
        for (int i = 0; i < N_FEAT; i++) begin
            if (fidx == FIDX_W'(i)) sel = feats[i*8 +: 8];
        end
    end

    assign bad_idx = 32'(fidx) >= N_FEAT;
    assign le      = (sel >> shift) <= thr;

endmodule

// File: rtl/dtree_seq_ctrl.sv
// Decision-tree sequencer: loads N_FEAT feature bytes, walks the node table one node
// per cycle and presents a class. Define DTREE_DEPTH_LIMIT_EN to cap visits at MAX_DEPTH.
module dtree_seq_ctrl
    import dtree_pkg::*;
#(
    parameter int N_FEAT    = 6,
    parameter int ADDR_W    = 8,
    parameter int MAX_DEPTH = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              feat_valid,
    output logic              feat_ready,
    input  logic [7:0]        feat_data,
    output logic [ADDR_W-1:0] node_addr,
    input  logic [NODE_W-1:0] node_data,
    output logic              cls_valid,
    input  logic              cls_ready,
    output logic [1:0]        cls,
    output logic              err,
    output logic              busy
);

    localparam int CNT_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_FEAT - 1);

    state_t              state_q, state_nxt;
    logic [CNT_W-1:0]    cnt_q, cnt_nxt, wr_idx;
    logic [N_FEAT*8-1:0] feats_q;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [1:0]          cls_nxt;
    logic                err_nxt;
    logic                fire, le, bad_idx;
    node_t               node;
    logic                unused_node_bits;

    assign node             = decode_node(node_data);
    assign unused_node_bits = ^node.rsvd;
    assign feat_ready       = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign fire             = feat_valid && feat_ready;
    assign wr_idx           = (state_q == ST_IDLE) ? '0 : cnt_q;
    assign busy             = state_q != ST_IDLE;
    assign cls_valid        = state_q == ST_DONE;

    dtree_node_cmp #(.N_FEAT(N_FEAT)) u_cmp (
        .feats   (feats_q),
        .fidx    (node.fidx),
        .shift   (node.shift),
        .thr     (node.thr),
        .le      (le),
        .bad_idx (bad_idx)
    );

`ifdef DTREE_DEPTH_LIMIT_EN
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_LAST = DEPTH_W'(MAX_DEPTH - 1);

    logic [DEPTH_W-1:0] depth_q, depth_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) depth_q <= '0;
        else        depth_q <= depth_nxt;
    end
`else
    localparam int unused_max_depth = MAX_DEPTH;
`endif

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        addr_nxt  = node_addr;
        cls_nxt   = cls;
        err_nxt   = err;
`ifdef DTREE_DEPTH_LIMIT_EN
        depth_nxt = depth_q;
`endif
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (fire) begin
                    cnt_nxt = wr_idx + 1'b1;
                    if (wr_idx == LAST_IDX) begin
                        state_nxt = ST_EVAL;
                        addr_nxt  = '0;
`ifdef DTREE_DEPTH_LIMIT_EN
                        depth_nxt = '0;
`endif
                    end else begin
                        state_nxt = ST_LOAD;
                    end
                end
            end
            ST_EVAL: begin
`ifdef DTREE_DEPTH_LIMIT_EN
                depth_nxt = depth_q + 1'b1;
`endif
                // Leaf wins over index check: leaves carry no meaningful feature index.
                if (node.leaf) begin
                    cls_nxt   = node.cls;
                    err_nxt   = 1'b0;
                    state_nxt = ST_DONE;
                end else if (bad_idx) begin
                    cls_nxt   = '0;
                    err_nxt   = 1'b1;
                    state_nxt = ST_DONE;
                end
`ifdef DTREE_DEPTH_LIMIT_EN
                else if (depth_q == DEPTH_LAST) begin
                    cls_nxt   = '0;
                    err_nxt   = 1'b1;
                    state_nxt = ST_DONE;
                end
`endif
                else if (le) begin
                    addr_nxt = node_addr + 1'b1;
                end else begin
                    addr_nxt = ADDR_W'(node.right);
                end
            end
            ST_DONE: begin
                if (cls_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            node_addr <= '0;
            cls       <= '0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            node_addr <= addr_nxt;
            cls       <= cls_nxt;
            err       <= err_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    feats_q <= '0;
        else if (fire) feats_q[wr_idx*8 +: 8] <= feat_data;
    end

endmodule

// File: tb/tb_dtree_seq_ctrl.sv
// Directed bench for dtree_seq_ctrl with a transaction-level tree-walk model checked every cycle.
module tb_dtree_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        feat_valid = 1'b0;
    logic        cls_ready = 1'b0;
    logic [7:0]  feat_data = 8'h00;
    logic        feat_ready, cls_valid, err, busy;
    logic [7:0]  node_addr;
    logic [27:0] node_data;
    logic [1:0]  cls;
    logic [27:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int          m_phase;   // 0 accepting features, 1 walking tree, 2 result presented
    int          m_nacc, m_step, m_len;
    logic        m_term, m_rerr, m_err;
    logic [1:0]  m_rcls, m_cls;
    logic [7:0]  m_feats [6];
    logic [7:0]  m_path [64];

    assign node_data = mem[node_addr];
    always #5 clk = ~clk;

    dtree_seq_ctrl #(.N_FEAT(6), .ADDR_W(8), .MAX_DEPTH(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .feat_valid (feat_valid),
        .feat_ready (feat_ready),
        .feat_data  (feat_data),
        .node_addr  (node_addr),
        .node_data  (node_data),
        .cls_valid  (cls_valid),
        .cls_ready  (cls_ready),
        .cls        (cls),
        .err        (err),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Walk the whole tree for the captured features, recording every visited address.
    function automatic void walk();
        logic [7:0]  a;
        logic [27:0] w;
        logic [7:0]  x;
        a = 8'h00; m_len = 0; m_term = 1'b0; m_rcls = 2'd0; m_rerr = 1'b0;
        while (!m_term && m_len < 64) begin
            m_path[m_len] = a;
            w = mem[a];
            m_len++;
            if (w[27]) begin
                m_term = 1'b1; m_rcls = w[1:0];
            end else if (w[26:24] > 3'd5) begin
                m_term = 1'b1; m_rerr = 1'b1;
            end
`ifdef DTREE_DEPTH_LIMIT_EN
            else if (m_len == 15) begin
                m_term = 1'b1; m_rerr = 1'b1;
            end
`endif
            else begin
                x = m_feats[w[26:24]] >> w[23:21];
                if (x <= w[20:13]) a = a + 8'd1;
                else               a = w[12:5];
            end
        end
    endfunction

    // Per-cycle compare against the model, then advance the model for the coming edge.
    initial begin
        m_phase = 0; m_nacc = 0; m_step = 0; m_len = 0;
        m_cls = 2'd0; m_err = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_phase = 0; m_nacc = 0; m_cls = 2'd0; m_err = 1'b0;
            end
            check("busy", busy, (m_phase != 0) || (m_nacc != 0));
            check("feat_ready", feat_ready, m_phase == 0);
            check("cls_valid", cls_valid, m_phase == 2);
            if (m_phase == 2 || !rst_n) begin
                check("cls", cls, m_cls);
                check("err", err, m_err);
            end
            if (!rst_n)
                check("node_addr_rst", node_addr, 0);
            else if (m_phase == 1 && m_step < m_len)
                check("node_addr", node_addr, m_path[m_step]);
            if (rst_n) begin
                case (m_phase)
                    0: if (feat_valid) begin
                        m_feats[m_nacc] = feat_data;
                        m_nacc++;
                        if (m_nacc == 6) begin
                            walk();
                            m_phase = 1; m_step = 0;
                        end
                    end
                    1: if (m_term && m_step == m_len - 1) begin
                        m_phase = 2; m_cls = m_rcls; m_err = m_rerr;
                    end else begin
                        m_step++;
                    end
                    default: if (cls_ready) begin
                        m_phase = 0; m_nacc = 0;
                    end
                endcase
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 28'h8000000;
    endtask

    task automatic send_feats(input logic [47:0] f, output time t_hs);
        int g;
        t_hs = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            feat_valid = 1'b1;
            feat_data  = f[i*8 +: 8];
            g = 0;
            @(negedge clk);
            while (!feat_ready && g < 50) begin
                g++;
                @(negedge clk);
            end
            if (!feat_ready) check("feat_ready_wait", feat_ready, 1);
            t_hs = $time;
        end
        @(posedge clk); #1;
        feat_valid = 1'b0;
    endtask

    task automatic get_result(input time t_hs, input logic [1:0] ecls, input logic eerr, input int elat);
        int g;
        g = 0;
        @(negedge clk);
        while (!cls_valid && g < 200) begin
            g++;
            @(negedge clk);
        end
        check("cls_valid_wait", cls_valid, 1);
        check("latency", int'(($time - t_hs) / 10), elat);
        check("result_cls", cls, ecls);
        check("result_err", err, eerr);
    endtask

    task automatic consume();
        @(posedge clk); #1 cls_ready = 1'b1;
        @(posedge clk); #1 cls_ready = 1'b0;
    endtask

    task automatic setup_deep_tree();
        clear_mem();
        mem[8'h00] = 28'h00C8200;   // X0 <= 100 ? 1 : 0x10
        mem[8'h10] = 28'h3E00400;   // X3>>7 <= 0 ? 0x11 : 0x20
        mem[8'h20] = 28'h2264600;   // X2>>1 <= 50 ? 0x21 : 0x30
        mem[8'h21] = 28'h800001D;   // leaf class 1, reserved bits set
    endtask

    initial begin
        time t;
        clear_mem();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_cls_valid", cls_valid, 0);
        check("rst_node_addr", node_addr, 0);
        check("rst_feat_ready", feat_ready, 1);
        check("rst_cls", cls, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;

        // single leaf root
        clear_mem();
        mem[0] = 28'h8000002;
        send_feats({8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10}, t);
        get_result(t, 2'd2, 1'b0, 2);
        consume();

        // compare true -> left child, compare false -> right child
        clear_mem();
        mem[8'h00] = 28'h5406800;
        mem[8'h01] = 28'h8000001;
        mem[8'h40] = 28'h8000003;
        send_feats({8'h0F, 40'h0}, t);
        get_result(t, 2'd1, 1'b0, 3);
        consume();
        send_feats({8'h10, 40'h0}, t);
        get_result(t, 2'd3, 1'b0, 3);
        consume();

        // bad feature index
        clear_mem();
        mem[0] = 28'h6000000;
        send_feats({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6}, t);
        get_result(t, 2'd0, 1'b1, 2);
        consume();

        // four-level walk with shifts across several features
        setup_deep_tree();
        send_feats({8'd0, 8'd0, 8'h80, 8'd100, 8'd0, 8'd200}, t);
        get_result(t, 2'd1, 1'b0, 5);
        consume();

        // backpressure: result held, feature pulses ignored
        clear_mem();
        mem[0] = 28'h8000002;
        send_feats({8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, t);
        get_result(t, 2'd2, 1'b0, 2);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            feat_valid = i[0];
            feat_data  = 8'hAA;
            @(negedge clk);
            check("bp_cls_valid", cls_valid, 1);
            check("bp_feat_ready", feat_ready, 0);
            check("bp_cls", cls, 2);
            check("bp_err", err, 0);
        end
        @(posedge clk); #1 feat_valid = 1'b0;
        consume();

        // self-looping tree: depth limit or endless walk
        clear_mem();
        mem[0] = 28'h0000000;
        send_feats({40'h0, 8'hFF}, t);
`ifdef DTREE_DEPTH_LIMIT_EN
        get_result(t, 2'd0, 1'b1, 16);
        consume();
`else
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check("loop_busy", busy, 1);
            check("loop_cls_valid", cls_valid, 0);
        end
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
`endif

        // reset in the middle of a walk, then a clean sample
        setup_deep_tree();
        send_feats({8'd0, 8'd0, 8'h80, 8'd100, 8'd0, 8'd200}, t);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cls_valid", cls_valid, 0);
        check("mid_rst_node_addr", node_addr, 0);
        check("mid_rst_cls", cls, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_feat_ready", feat_ready, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        send_feats({8'd0, 8'd0, 8'h80, 8'd100, 8'd0, 8'd200}, t);
        get_result(t, 2'd1, 1'b0, 5);
        consume();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
